// File: rtl/renkon_ctrl_output_pkg.sv
`default_nettype none
//============================================================================
// Module   : renkon_ctrl_output_pkg
// Brief    : Shared renkon/ninjin constants and drain FSM state encoding.
// Revision : 1.0 - initial release
//============================================================================
package renkon_ctrl_output_pkg;

    localparam int RENKON_CORE     = 8;
    localparam int RENKON_CORELOG  = 3;
    localparam int RENKON_OWIDTH   = 10;
    localparam int NINJIN_DWIDTH   = 16;
    localparam int NINJIN_MEMWIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/renkon_ctrl_output_pipe.sv
`default_nettype none
//============================================================================
// Module   : renkon_ctrl_output_pipe
// Brief    : Two-stage valid/core shift register: stage 1 drives the mux
//            select, stage 2 the result memory write enable.
// Revision : 1.0 - initial release
//============================================================================
module renkon_ctrl_output_pipe
    import renkon_ctrl_output_pkg::*;
#(
    parameter int CORELOG = RENKON_CORELOG
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               i_valid,
    input  logic [CORELOG:0]   i_core,
    output logic [CORELOG:0]   o_output_re,
    output logic               o_mem_we,
    output logic               o_wr_adv
);

    localparam logic [CORELOG:0] C_CORE_ONE = (CORELOG+1)'(1);

    logic               r_s1_valid;
    logic [CORELOG:0]   r_s1_core;
    logic               r_s2_valid;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_s1_valid <= 1'b0;
            r_s1_core  <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_core  <= i_core;
            r_s2_valid <= r_s1_valid;
        end
    end

    // Select encodes core c as c+1 so that 0 can mean "no core".
    assign o_output_re = r_s1_valid ? (r_s1_core + C_CORE_ONE) : '0;
    assign o_mem_we    = r_s2_valid;
    assign o_wr_adv    = r_s1_valid;

endmodule
`default_nettype wire

// File: rtl/renkon_ctrl_output.sv
`default_nettype none
//============================================================================
// Module   : renkon_ctrl_output
// Brief    : Output drain scheduler: walks every active core buffer and
//            issues one result memory write per word, core-major order.
// Revision : 1.0 - initial release
//============================================================================
module renkon_ctrl_output
    import renkon_ctrl_output_pkg::*;
#(
    parameter int DWIDTH   = NINJIN_DWIDTH,
    parameter int CORE     = RENKON_CORE,
    parameter int CORELOG  = RENKON_CORELOG,
    parameter int OWIDTH   = RENKON_OWIDTH,
    parameter int MEMWIDTH = NINJIN_MEMWIDTH
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 req,
    input  logic [OWIDTH-1:0]    out_size,
    input  logic [CORELOG:0]     core_num,
    input  logic [MEMWIDTH-1:0]  mem_base,
    output logic                 busy,
    output logic                 ack,
    output logic [OWIDTH-1:0]    output_addr,
    output logic [CORELOG:0]     output_re,
    output logic                 mem_we,
    output logic [MEMWIDTH-1:0]  mem_addr
);

    localparam logic [CORELOG:0]    C_CORE_MAX = (CORELOG+1)'(CORE);
    localparam logic [CORELOG:0]    C_CORE_ONE = (CORELOG+1)'(1);
    localparam logic [OWIDTH-1:0]   C_ADDR_ONE = OWIDTH'(1);
    localparam logic [MEMWIDTH-1:0] C_MEM_ONE  = MEMWIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [OWIDTH-1:0]     r_size;
    logic [OWIDTH-1:0]     r_addr;
    logic [CORELOG:0]      r_cores;
    logic [CORELOG:0]      r_core;
    logic [CORELOG:0]      w_cores_clamped;
    logic                  r_flush;
    logic                  r_ack;
    logic [MEMWIDTH-1:0]   r_wr_addr;
    logic [MEMWIDTH-1:0]   r_mem_addr;
    logic                  w_empty;
    logic                  w_last_addr;
    logic                  w_last_core;
    logic                  w_last_issue;
    logic                  w_issue;
    logic                  w_wr_adv;

    assign w_cores_clamped = (core_num > C_CORE_MAX) ? C_CORE_MAX : core_num;
    assign w_empty         = (out_size == '0) || (core_num == '0);
    assign w_last_addr     = (r_addr == (r_size - C_ADDR_ONE));
    assign w_last_core     = (r_core == (r_cores - C_CORE_ONE));
    assign w_last_issue    = w_last_addr && w_last_core;
    assign w_issue         = (r_state == S_ISSUE);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next_state = w_empty ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (w_last_issue) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (r_flush) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_size  <= '0;
            r_cores <= '0;
            r_addr  <= '0;
            r_core  <= '0;
            r_flush <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_size  <= out_size;
                        r_cores <= w_cores_clamped;
                        r_addr  <= '0;
                        r_core  <= '0;
                        r_flush <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (!w_last_issue) begin
                        if (w_last_addr) begin
                            r_addr <= '0;
                            r_core <= r_core + C_CORE_ONE;
                        end else begin
                            r_addr <= r_addr + C_ADDR_ONE;
                        end
                    end
                end
                S_FLUSH: begin
                    r_flush <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Running write address replaces base + core*size + addr; it advances
    // one cycle ahead of mem_we so mem_addr lands with the write strobe.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_wr_addr  <= '0;
            r_mem_addr <= '0;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= (r_state == S_DONE);
            if ((r_state == S_IDLE) && req) begin
                r_wr_addr <= mem_base;
            end else if (w_wr_adv) begin
                r_mem_addr <= r_wr_addr;
                r_wr_addr  <= r_wr_addr + C_MEM_ONE;
            end
        end
    end

    generate
        if (DWIDTH > 0) begin : g_pipe
            renkon_ctrl_output_pipe #(
                .CORELOG     (CORELOG)
            ) u_pipe (
                .clk         (clk),
                .xrst        (xrst),
                .i_valid     (w_issue),
                .i_core      (r_core),
                .o_output_re (output_re),
                .o_mem_we    (mem_we),
                .o_wr_adv    (w_wr_adv)
            );
        end
    endgenerate

    assign ack         = r_ack;
    assign output_addr = r_addr;
    assign mem_addr    = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_renkon_ctrl_output.sv
`default_nettype none
//============================================================================
// Module   : tb_renkon_ctrl_output
// Brief    : Scoreboard bench for the renkon output drain scheduler with a
//            model of the core buffers and the registered output mux.
// Revision : 1.0 - initial release
//============================================================================
module tb_renkon_ctrl_output;

    localparam int OW = 10;
    localparam int MW = 16;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic           clk = 1'b0;
    logic           xrst;
    logic           req;
    logic [OW-1:0]  out_size;
    logic [3:0]     core_num;
    logic [MW-1:0]  mem_base;
    logic           busy;
    logic           ack;
    logic [OW-1:0]  output_addr;
    logic [3:0]     output_re;
    logic           mem_we;
    logic [MW-1:0]  mem_addr;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];
    int  exp_re_q[$];
    int  re_q[$];

    logic [15:0] rd_data [8];
    logic [15:0] mux_data;

    renkon_ctrl_output u_dut (
        .clk         (clk),
        .xrst        (xrst),
        .req         (req),
        .out_size    (out_size),
        .core_num    (core_num),
        .mem_base    (mem_base),
        .busy        (busy),
        .ack         (ack),
        .output_addr (output_addr),
        .output_re   (output_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] buf_data(input int c, input int a);
        return 16'(((c + 1) << 12) | a) ^ 16'h0C3C;
    endfunction

    // Core buffers (1-cycle read) feeding the registered output mux.
    always @(posedge clk) begin
        for (int c = 0; c < 8; c++) rd_data[c] <= buf_data(c, int'(output_addr));
        if (output_re != 4'd0 && output_re <= 4'd8) mux_data <= rd_data[output_re - 4'd1];
        else mux_data <= 16'h0000;
    end

    always @(negedge clk) begin
        if (xrst && mem_we) obs_q.push_back('{mem_addr, mux_data, cyc});
        if (xrst && output_re != 4'd0) re_q.push_back(int'(output_re));
    end

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        exp_re_q.delete();
        re_q.delete();
    endtask

    task automatic start_drain(input int size, input int cores, input int base, output int k);
        int nc;
        int i;
        @(posedge clk); #1;
        out_size = OW'(size);
        core_num = 4'(cores);
        mem_base = 16'(base);
        req      = 1'b1;
        k        = cyc;
        nc       = (cores > 8) ? 8 : cores;
        i        = 0;
        for (int c = 0; c < nc; c++) begin
            for (int a = 0; a < size; a++) begin
                exp_q.push_back('{16'(base + i), buf_data(c, a), k + 3 + i});
                exp_re_q.push_back(c + 1);
                i++;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_ack(input int bound, output int ack_cyc);
        ack_cyc = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (ack) begin
                ack_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int k;
        xrst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, ack, output_addr, output_re, mem_we, mem_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_state got busy=%b ack=%b addr=%h re=%h we=%b maddr=%h, want all 0",
                     busy, ack, output_addr, output_re, mem_we, mem_addr);
        end
        @(posedge clk); #1;
        xrst = 1'b1;
        start_drain(8, 4, 0, k);
        repeat (21) @(posedge clk);
        #1;
        n_cmp++;
        if (output_addr !== 10'd5 || output_re !== 4'd3) begin
            n_err++;
            $display("FAIL reset_pre got addr=%0d re=%0d, want addr=5 re=3", output_addr, output_re);
        end
        xrst = 1'b0;
        #1;
        clear_queues();
        n_cmp++;
        if (output_addr !== '0 || output_re !== '0 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL reset_async_path got addr=%h re=%h maddr=%h, want 0", output_addr, output_re, mem_addr);
        end
        n_cmp++;
        if (busy !== 1'b0 || ack !== 1'b0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async_ctl got busy=%b ack=%b we=%b, want 0", busy, ack, mem_we);
        end
        @(posedge clk); #1;
        xrst = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || re_q.size() !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after got writes=%0d re_events=%0d busy=%b, want 0 0 0",
                     obs_q.size(), re_q.size(), busy);
        end
        clear_queues();
    endtask

    task automatic test_basic();
        int  k;
        int  ack_cyc;
        int  n_obs;
        int  last_we;
        wr_t e;
        wr_t o;
        clear_queues();
        start_drain(3, 2, 16'h100, k);
        wait_ack(50, ack_cyc);
        n_cmp++;
        if (ack_cyc !== k + 10) begin
            n_err++;
            $display("FAIL basic_ack_cycle got %0d, want %0d", ack_cyc - k, 10);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_at_ack got %b, want 0", busy);
        end
        n_obs = obs_q.size();
        n_cmp++;
        if (n_obs !== 6) begin
            n_err++;
            $display("FAIL basic_count got %0d writes, want 6", n_obs);
        end
        last_we = (n_obs > 0) ? obs_q[n_obs - 1].cyc : -100;
        n_cmp++;
        if (ack_cyc !== last_we + 2) begin
            n_err++;
            $display("FAIL basic_ack_vs_we got ack %0d cycles after last write, want 2", ack_cyc - last_we);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL basic_wr got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                         o.addr, o.data, o.cyc - k, e.addr, e.data, e.cyc - k);
            end
        end
        n_cmp++;
        if (re_q.size() !== exp_re_q.size()) begin
            n_err++;
            $display("FAIL basic_re_len got %0d, want %0d", re_q.size(), exp_re_q.size());
        end
        while (exp_re_q.size() > 0 && re_q.size() > 0) begin
            int er;
            int orr;
            er  = exp_re_q.pop_front();
            orr = re_q.pop_front();
            n_cmp++;
            if (orr !== er) begin
                n_err++;
                $display("FAIL basic_re got %0d, want %0d", orr, er);
            end
        end
        clear_queues();
    endtask

    task automatic test_latency();
        int k;
        int ack_cyc;
        clear_queues();
        start_drain(4, 1, 16'h20, k);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || output_addr !== 10'd0 || output_re !== 4'd0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL lat_t0 got busy=%b addr=%0d re=%0d we=%b, want 1 0 0 0",
                     busy, output_addr, output_re, mem_we);
        end
        @(negedge clk);
        n_cmp++;
        if (output_re !== 4'd1 || output_addr !== 10'd1 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL lat_t1 got re=%0d addr=%0d we=%b, want 1 1 0", output_re, output_addr, mem_we);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h20 || output_addr !== 10'd2) begin
            n_err++;
            $display("FAIL lat_t2 got we=%b maddr=%h addr=%0d, want 1 0020 2", mem_we, mem_addr, output_addr);
        end
        wait_ack(50, ack_cyc);
        n_cmp++;
        if (ack_cyc !== k + 8 || obs_q.size() !== 4) begin
            n_err++;
            $display("FAIL lat_done got ack_at=%0d writes=%0d, want 8 4", ack_cyc - k, obs_q.size());
        end
        clear_queues();
    endtask

    task automatic test_degenerate();
        int k;
        int ack_cyc;
        int sizes [2];
        int cores [2];
        sizes = '{0, 5};
        cores = '{3, 0};
        for (int t = 0; t < 2; t++) begin
            clear_queues();
            start_drain(sizes[t], cores[t], 16'h40, k);
            wait_ack(20, ack_cyc);
            n_cmp++;
            if (ack_cyc !== k + 2) begin
                n_err++;
                $display("FAIL degen_ack size=%0d cores=%0d got ack_at=%0d, want 2", sizes[t], cores[t], ack_cyc - k);
            end
            repeat (3) @(negedge clk);
            n_cmp++;
            if (obs_q.size() !== 0 || re_q.size() !== 0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL degen_quiet size=%0d cores=%0d got writes=%0d re_events=%0d busy=%b, want 0 0 0",
                         sizes[t], cores[t], obs_q.size(), re_q.size(), busy);
            end
        end
        clear_queues();
    endtask

    task automatic test_full_clamp();
        int  k;
        int  ack_cyc;
        int  errs;
        wr_t e;
        wr_t o;
        clear_queues();
        start_drain(1023, 15, 16'hFFFE, k);
        wait_ack(9000, ack_cyc);
        n_cmp++;
        if (ack_cyc !== k + 8184 + 4) begin
            n_err++;
            $display("FAIL full_ack got ack_at=%0d, want %0d", ack_cyc - k, 8188);
        end
        n_cmp++;
        if (obs_q.size() !== 8184) begin
            n_err++;
            $display("FAIL full_count got %0d writes, want 8184", obs_q.size());
        end
        n_cmp++;
        if (obs_q.size() < 3 || obs_q[1].addr !== 16'hFFFF || obs_q[2].addr !== 16'h0000) begin
            n_err++;
            $display("FAIL full_wrap got writes 1,2 at %h %h, want FFFF 0000",
                     (obs_q.size() > 1) ? obs_q[1].addr : 16'hxxxx,
                     (obs_q.size() > 2) ? obs_q[2].addr : 16'hxxxx);
        end
        n_cmp++;
        if (re_q.size() === 0 || re_q[re_q.size() - 1] !== 8) begin
            n_err++;
            $display("FAIL full_last_re got %0d, want 8", (re_q.size() > 0) ? re_q[re_q.size() - 1] : -1);
        end
        errs = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                n_err++;
                errs++;
                if (errs <= 20)
                    $display("FAIL full_wr got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                             o.addr, o.data, o.cyc - k, e.addr, e.data, e.cyc - k);
            end
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        int  k;
        int  k2;
        int  ack_cyc;
        wr_t e;
        wr_t o;
        clear_queues();
        start_drain(4, 2, 16'h300, k);
        @(posedge clk); #1;
        out_size = 10'd7;
        core_num = 4'd1;
        mem_base = 16'h0999;
        req      = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_ack(50, ack_cyc);
        n_cmp++;
        if (ack_cyc !== k + 12 || obs_q.size() !== 8) begin
            n_err++;
            $display("FAIL busyreq_done got ack_at=%0d writes=%0d, want 12 8", ack_cyc - k, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                n_err++;
                $display("FAIL busyreq_wr got addr=%h data=%h, want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
            end
        end
        clear_queues();
        start_drain(2, 3, 16'h400, k2);
        wait_ack(50, ack_cyc);
        n_cmp++;
        if (ack_cyc !== k2 + 10 || obs_q.size() !== 6) begin
            n_err++;
            $display("FAIL b2b_done got ack_at=%0d writes=%0d, want 10 6", ack_cyc - k2, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL b2b_wr got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                         o.addr, o.data, o.cyc - k2, e.addr, e.data, e.cyc - k2);
            end
        end
        clear_queues();
    endtask

    initial begin
        xrst     = 1'b0;
        req      = 1'b0;
        out_size = '0;
        core_num = '0;
        mem_base = '0;
        test_reset();
        test_basic();
        test_latency();
        test_degenerate();
        test_full_clamp();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
